// File: rtl/utm_pkg.sv
// Shared definitions for the universal Turing machine tape path.
// Holds the symbol width, the blank symbol, the tape controller state
// encoding and the one-hot machine-state width used by the state logic.
package utm_pkg;

  localparam int SYM_W    = 3;
  localparam int MSTATE_W = 8;

  localparam logic [SYM_W-1:0] BLANK = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_MOVE  = 3'd3,
    ST_HALT  = 3'd4
  } tape_st_e;

  // True when a one-cell move from 'head' would fall off a tape whose last
  // index is 'last'.
  function automatic logic off_tape(input logic [5:0] head,
                                    input logic [5:0] last,
                                    input logic       right);
    return right ? (head == last) : (head == 6'd0);
  endfunction

endpackage

// File: rtl/tape_mem.sv
// Tape cell storage: TAPE_LEN x SYM_W registers, one synchronous write
// port, one combinational read port, every cell resets to BLANK.
module tape_mem #(
  parameter int TAPE_LEN = 16,
  parameter int SYM_W    = 3,
  parameter int AW       = $clog2(TAPE_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [SYM_W-1:0] rdata
);
  import utm_pkg::*;

  logic [TAPE_LEN-1:0][SYM_W-1:0] cells_q, cells_d;

  // Next cell contents: only the addressed cell changes on a write.
  always_comb begin
    cells_d = cells_q;
    if (we) cells_d[waddr] = wdata;
  end

  // Cell registers; reset clears the whole tape to blanks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPE_LEN; i++) cells_q[i] <= BLANK;
    end else begin
      cells_q <= cells_d;
    end
  end

  assign rdata = cells_q[raddr];

endmodule

// File: rtl/tape_head.sv
// Tape store and head controller. Presents the symbol under the head to the
// next-symbol lookup, writes back the lookup result and moves the head.
// Step sequence: IDLE -> FETCH -> WRITE -> MOVE -> IDLE (one step / 4 cycles).
// Optional feature macro: UTM_TAPE_WRAP_EN makes the tape circular; the
// head then wraps at both ends and edge_err never asserts.
module tape_head #(
  parameter int TAPE_LEN  = 16,
  parameter int HEAD_INIT = 0,
  parameter int SYM_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_en,
  input  logic [SYM_W-1:0]            load_sym,
  input  logic                        step,
  output logic [SYM_W-1:0]            sym_rd,
  output logic                        rd_valid,
  input  logic [SYM_W-1:0]            sym_wr,
  input  logic                        move_right,
  input  logic                        halt_in,
  output logic                        busy,
  output logic                        done,
  output logic                        halted,
  output logic                        edge_err,
  output logic [$clog2(TAPE_LEN)-1:0] head_pos
);
  import utm_pkg::*;

  localparam int            AW    = $clog2(TAPE_LEN);
  localparam logic [AW-1:0] LAST  = AW'(TAPE_LEN - 1);
  localparam logic [AW-1:0] HINIT = AW'(HEAD_INIT);

  tape_st_e         state_q, state_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    load_ptr_q, load_ptr_d;
  logic [SYM_W-1:0] sym_rd_q, sym_rd_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             halted_q, halted_d;
  logic             edge_err_q, edge_err_d;
  logic             dir_q, dir_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [SYM_W-1:0] mem_wdata;
  logic [SYM_W-1:0] mem_rdata;

  // leave_now judges the move requested during WRITE (so done can be
  // registered to show in the MOVE cycle); leave_lat judges the direction
  // latched for MOVE itself. Both see the same head and direction.
  logic leave_now, leave_lat;

`ifdef UTM_TAPE_WRAP_EN
  // Circular tape: no move ever leaves it.
  assign leave_now = 1'b0;
  assign leave_lat = 1'b0;
`else
  // Bounded tape: stepping past either end is an edge error.
  assign leave_now = off_tape(6'(head_q), 6'(LAST), move_right);
  assign leave_lat = off_tape(6'(head_q), 6'(LAST), dir_q);
`endif

  tape_mem #(
    .TAPE_LEN (TAPE_LEN),
    .SYM_W    (SYM_W),
    .AW       (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (head_q),
    .rdata (mem_rdata)
  );

  // Step sequencing, preload, head movement and registered status outputs.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    load_ptr_d = load_ptr_q;
    sym_rd_d   = sym_rd_q;
    rd_valid_d = rd_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    halted_d   = halted_q;
    edge_err_d = edge_err_q;
    dir_d      = dir_q;
    mem_we     = 1'b0;
    mem_waddr  = head_q;
    mem_wdata  = sym_wr;

    unique case (state_q)
      ST_IDLE: begin
        // Preload has priority; a step in the same cycle is dropped.
        if (load_en) begin
          mem_we     = 1'b1;
          mem_waddr  = load_ptr_q;
          mem_wdata  = load_sym;
          load_ptr_d = load_ptr_q + AW'(1);
        end else if (step && !halted_q) begin
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        sym_rd_d   = mem_rdata;
        rd_valid_d = 1'b1;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        // The lookup has had a full cycle to settle from sym_rd.
        if (halt_in) begin
          halted_d   = 1'b1;
          busy_d     = 1'b0;
          rd_valid_d = 1'b0;
          state_d    = ST_HALT;
        end else begin
          mem_we  = 1'b1;
          dir_d   = move_right;
          done_d  = !leave_now;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        busy_d = 1'b0;
        if (leave_lat) begin
          edge_err_d = 1'b1;
          halted_d   = 1'b1;
          rd_valid_d = 1'b0;
          state_d    = ST_HALT;
        end else begin
          head_d  = dir_q ? head_q + AW'(1) : head_q - AW'(1);
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        busy_d     = 1'b0;
        rd_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset aborts any step in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      head_q     <= HINIT;
      load_ptr_q <= '0;
      sym_rd_q   <= BLANK;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
      edge_err_q <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      load_ptr_q <= load_ptr_d;
      sym_rd_q   <= sym_rd_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      halted_q   <= halted_d;
      edge_err_q <= edge_err_d;
      dir_q      <= dir_d;
    end
  end

  assign sym_rd   = sym_rd_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign halted   = halted_q;
  assign edge_err = edge_err_q;
  assign head_pos = head_q;

endmodule

// File: doc/tape_head.md
Name: tape_head

Overview:
- Sequential tape store and head controller for the universal Turing machine.
- It holds the tape cells and presents the symbol under the head to the transition logic as s2/s1/s0.
- Each step it captures the new symbol computed from that read, writes it back, and moves the head.
- It is the writer/storage end of the symbol path whose combinational next-symbol lookup it feeds and consumes.

Parameters:
- TAPE_LEN, 16: number of tape cells; power of two, 4..64.
- HEAD_INIT, 0: head position after reset; must be less than TAPE_LEN.
- SYM_W, 3: symbol width in bits; fixed at 3 for the current lookup.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  tape preload strobe; one cell written per cycle.
- load_sym  in  SYM_W  preload symbol.
- step  in  1  request one machine step; level-sampled.
- sym_rd  out  SYM_W  symbol under head, to the lookup inputs s2/s1/s0.
- rd_valid  out  1  sym_rd is stable for this step.
- sym_wr  in  SYM_W  new symbol from the lookup (z2/z1/z0).
- move_right  in  1  1 = head +1, 0 = head -1.
- halt_in  in  1  machine halt indication from state logic.
- busy  out  1  step in progress.
- done  out  1  one-cycle pulse at step completion.
- halted  out  1  sticky; set by halt_in or edge error.
- edge_err  out  1  sticky; head tried to leave the tape.
- head_pos  out  clog2(TAPE_LEN)  current head index.

Behaviour:
- Reset (asynchronous):
  - all cells = BLANK (000).
  - head_pos = HEAD_INIT; load pointer = 0.
  - sym_rd = 000.
  - rd_valid, busy, done, halted and edge_err all 0.
  - FSM = IDLE.
- FSM states: IDLE, FETCH, WRITE, MOVE, HALT.
- IDLE:
  - If load_en: write load_sym to cell[load_ptr]; load_ptr increments and wraps modulo TAPE_LEN. step is ignored in the same cycle.
  - Else if step and not halted: go to FETCH, busy = 1.
- FETCH: sym_rd <= cell[head_pos]; rd_valid = 1 from the next cycle; go to WRITE.
- WRITE: the transition logic settles combinationally from sym_rd.
  - If halt_in: no write; halted = 1; go to HALT.
  - Else: cell[head_pos] <= sym_wr; latch move_right; go to MOVE.
- MOVE:
  - Moving left at 0, or right at TAPE_LEN-1: edge_err = 1, halted = 1, head unchanged, go to HALT.
  - Otherwise: head updated; done = 1 for this cycle; busy = 0; go to IDLE.
- HALT: terminal; busy = 0; rd_valid = 0. Only reset exits.
- Latency: step seen in IDLE at cycle N gives sym_rd valid at N+2, write at N+2 edge, done at N+3. Throughput is one step per 4 cycles if step is held high.
- rd_valid stays high until the next FETCH, except in HALT.
- load_en outside IDLE is ignored.
- A held step re-triggers from IDLE every return.
- Reset mid-step aborts the step with no partial write surviving, because the cells reset too.

Optional Feature:
- Macro: UTM_TAPE_WRAP_EN.
- Defined:
  - The tape is circular; head wraps (0 -1 becomes TAPE_LEN-1, and TAPE_LEN-1 +1 becomes 0).
  - edge_err is tied to 0; MOVE never enters HALT.
- Undefined: edge-error behaviour as above.

Decomposition:
- Shared package utm_pkg holds:
  - SYM_W, the BLANK symbol constant (000).
  - The tape FSM state enum (IDLE, FETCH, WRITE, MOVE, HALT).
  - The one-hot machine-state width (8).
- Sub-module tape_mem: TAPE_LEN x SYM_W register array.
  - One synchronous write port, one combinational read port.
  - Async reset to BLANK.
  - Instantiated once; the FSM and head logic stay in tape_head.

Test Plan:
- Reset, then read cell 0 via one step with sym_wr=010, move_right=1: sym_rd=000, cell0=010, head_pos=1, done pulses at N+3.
- Preload 4 cycles with 001,101,110,111, then 3 steps right, each with sym_wr=sym_rd: sym_rd sequence 001,101,110; tape unchanged.
- head_pos=0, step with move_right=0:
  - without wrap: edge_err=1, halted=1, head stays 0, no done.
  - with UTM_TAPE_WRAP_EN: head_pos=TAPE_LEN-1 (15), done pulses.
- halt_in=1 during WRITE: cell unchanged, halted=1, later steps ignored, busy=0.
- Assert rst_n low in WRITE cycle: all outputs at reset values immediately, cell under head = 000.
- step held high 8 cycles: exactly 2 done pulses, 4 cycles apart.
